bcd_up_counter_n: RTL and testbench
===================================

// Module: bcd_up_counter_n
//
// PURPOSE
//   Synchronous N-digit BCD up-counter: counts 0..(10^DIGITS-1), then wraps to 0.
//   It is the count-up counterpart of the team's single-digit decade down-counter.
//   Used for event tallies and display counters that feed the 7-segment decoders.
//   Supports parallel BCD load with digit validation.
//   CO is a combinational ripple carry, so several instances cascade (CO -> next EN).
//
// PARAMETERS
//   DIGITS   2   number of BCD digits (>=1); Q width = 4*DIGITS
//
// PORTS
//   CLK  in   1          rising-edge clock, the only clock
//   MR   in   1          reset: synchronous, active-high
//   EN   in   1          count enable (increment by 1 on this edge)
//   LD   in   1          parallel load strobe
//   D    in   4*DIGITS   load value, BCD, digit i = D[4i+3:4i]
//   Q    out  4*DIGITS   count, BCD, digit 0 = least significant
//   CO   out  1          carry out = EN & ~MR & (every digit of Q == 9)
//   ERR  out  1          registered 1-cycle pulse: the last LD was rejected
//
// BEHAVIOUR
//   Reset and outputs
//   - MR=1 at a CLK edge: Q <= 0, ERR <= 0. MR beats LD and EN.
//   - While MR=1, CO = 0.
//   - Q and ERR are registers; CO is combinational.
//   Priority per edge: MR > LD > EN > hold.
//   Load (LD=1, MR=0)
//   - If every digit of D is <= 9: Q <= D and ERR <= 0.
//   - If any digit of D is > 9: Q holds and ERR <= 1.
//   - EN is ignored in a load cycle; no increment happens.
//   - ERR is high for exactly the one cycle after the rejecting edge.
//     It clears on the next edge unless another rejected load occurs.
//   Count (EN=1, LD=0, MR=0)
//   - Digit 0 increments by 1.
//   - A digit equal to 9 becomes 0 and passes a carry to the next digit.
//   - A carry into a digit below 9 increments that digit and stops there.
//   - All digits 9 -> all digits 0 (wrap). CO is high during that cycle.
//   - ERR <= 0.
//   Hold (EN=0, LD=0, MR=0): Q holds, ERR <= 0.
//   Robustness: a digit > 9 cannot be reached through the ports. If one is
//   present, it is treated as 9 on increment: it becomes 0 and carries.
//   Latency: Q reflects LD/EN one edge later. CO follows Q and EN in the same
//   cycle, with no register.
//   Cascade: instance k+1 takes EN = CO of instance k. All instances share CLK and MR.
//   Width rule: each digit's increment uses 4-bit arithmetic; no binary carry
//   crosses a digit boundary.
//
// TESTING (DIGITS=2)
//   1. MR=1 for 1 edge with LD=1, EN=1, D=8'h55 -> Q=8'h00, ERR=0, CO=0.
//   2. EN=1 for 100 edges from 00 -> Q steps 00,01..09,10..99,00.
//      CO=1 only while Q=8'h99. After edge 100, Q=8'h00.
//   3. LD=1, EN=1, D=8'h47 -> Q=8'h47, not 48. Then EN=1 -> Q=8'h48, ERR=0.
//   4. Q=8'h12, LD=1, D=8'h3A -> Q stays 8'h12, ERR=1 for one cycle, then 0.
//      Repeat with D=8'hF0: same response.
//   5. Load 8'h99 with EN=0 -> CO=0, Q holds. Raise EN -> CO=1 in the same cycle.
//      Next edge -> Q=8'h00, CO=0.
//   6. Mid-count at Q=8'h63, assert MR with EN=1 -> next edge Q=8'h00.
//      Release MR -> counting resumes 01,02.

Source files
------------

// File: rtl/bcd_up_counter_n_if.sv
// Control/data bundle for the N-digit BCD up-counter.
// The master drives enable/load/data; the slave returns count, carry and error.
interface bcd_up_counter_n_if #(
  parameter int unsigned Digits = 2
);
  logic                  en;
  logic                  ld;
  logic [4*Digits-1:0]   d;
  logic [4*Digits-1:0]   q;
  logic                  co;
  logic                  err;

  modport master (
    output en,
    output ld,
    output d,
    input  q,
    input  co,
    input  err
  );

  modport slave (
    input  en,
    input  ld,
    input  d,
    output q,
    output co,
    output err
  );
endinterface

// File: rtl/bcd_up_counter_n.sv
// Synchronous N-digit BCD up-counter with validated parallel load.
// co is a combinational ripple carry so instances cascade via co -> next en.
module bcd_up_counter_n #(
  parameter int unsigned Digits = 2
) (
  input  logic                  clk_i,
  input  logic                  mr_i,
  bcd_up_counter_n_if.slave     bus
);
  localparam int unsigned Width = 4 * Digits;

  logic [Width-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [Width-1:0] q_inc;
  logic [Digits:0]  carry;
  logic             d_valid;
  logic             all_nine;

  // Per-digit 4-bit increment; a digit >= 9 (including illegal codes) wraps to 0 and carries.
  always_comb begin
    q_inc    = q_q;
    carry    = '0;
    carry[0] = 1'b1;
    d_valid  = 1'b1;
    all_nine = 1'b1;
    for (int i = 0; i < int'(Digits); i++) begin
      if (carry[i]) begin
        if (q_q[4*i +: 4] >= 4'd9) begin
          q_inc[4*i +: 4] = 4'd0;
          carry[i+1]      = 1'b1;
        end else begin
          q_inc[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
        end
      end
      if (bus.d[4*i +: 4] > 4'd9) begin
        d_valid = 1'b0;
      end
      if (q_q[4*i +: 4] != 4'd9) begin
        all_nine = 1'b0;
      end
    end
  end

  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (mr_i) begin
      q_d = '0;
    end else if (bus.ld) begin
      if (d_valid) begin
        q_d = bus.d;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      q_d = q_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    q_q   <= q_d;
    err_q <= err_d;
  end

  assign bus.q   = q_q;
  assign bus.err = err_q;
  assign bus.co  = bus.en & ~mr_i & all_nine;
endmodule

// File: tb/tb_bcd_up_counter_n.sv
// Scoreboard bench for the 2-digit BCD up-counter: the driver queues expected
// (q, co, err) per cycle and a negedge monitor pops and compares.
module tb_bcd_up_counter_n;
  localparam int unsigned Digits = 2;

  typedef struct packed {
    logic [7:0] q;
    logic       co;
    logic       err;
    logic [7:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic mr;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bcd_up_counter_n_if #(.Digits(Digits)) bus ();

  bcd_up_counter_n #(.Digits(Digits)) dut (
    .clk_i (clk),
    .mr_i  (mr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int k);
    logic [7:0] r;
    r[7:4] = 4'((k / 10) % 10);
    r[3:0] = 4'(k % 10);
    return r;
  endfunction

  // Apply inputs just after an edge; expectation is the state seen during this cycle.
  task automatic step(input logic s_mr, input logic s_ld, input logic s_en,
                      input logic [7:0] s_d, input logic [7:0] e_q,
                      input logic e_co, input logic e_err, input logic [7:0] tag);
    exp_t e;
    @(posedge clk);
    #1;
    mr     = s_mr;
    bus.ld = s_ld;
    bus.en = s_en;
    bus.d  = s_d;
    e.q    = e_q;
    e.co   = e_co;
    e.err  = e_err;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.q !== e.q || bus.co !== e.co || bus.err !== e.err) begin
          errors++;
          $display("FAIL step%0d: got q=%h co=%b err=%b, want q=%h co=%b err=%b",
                   e.tag, bus.q, bus.co, bus.err, e.q, e.co, e.err);
        end
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    mr     = 1'b1;
    bus.ld = 1'b1;
    bus.en = 1'b1;
    bus.d  = 8'h55;
    // Reset beats load and enable.
    step(1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0, 8'd1);
    // Full count sweep through wrap.
    for (int k = 0; k < 100; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00, to_bcd(k), (k == 99), 1'b0, 8'd2);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd3);
    // Load wins over enable.
    step(1'b0, 1'b1, 1'b1, 8'h47, 8'h00, 1'b0, 1'b0, 8'd4);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h47, 1'b0, 1'b0, 8'd5);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h48, 1'b0, 1'b0, 8'd6);
    // Rejected loads.
    step(1'b0, 1'b1, 1'b0, 8'h12, 8'h48, 1'b0, 1'b0, 8'd7);
    step(1'b0, 1'b1, 1'b0, 8'h3A, 8'h12, 1'b0, 1'b0, 8'd8);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h12, 1'b0, 1'b1, 8'd9);
    step(1'b0, 1'b1, 1'b0, 8'hF0, 8'h12, 1'b0, 1'b0, 8'd10);
    step(1'b0, 1'b1, 1'b0, 8'hA0, 8'h12, 1'b0, 1'b1, 8'd11);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h12, 1'b0, 1'b1, 8'd12);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h12, 1'b0, 1'b0, 8'd13);
    // CO is combinational on en at 99.
    step(1'b0, 1'b1, 1'b0, 8'h99, 8'h12, 1'b0, 1'b0, 8'd14);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0, 8'd15);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h99, 1'b1, 1'b0, 8'd16);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd17);
    // Mid-count reset and resume.
    step(1'b0, 1'b1, 1'b0, 8'h63, 8'h00, 1'b0, 1'b0, 8'd18);
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h63, 1'b0, 1'b0, 8'd19);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'd20);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 8'd21);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 8'd22);
    // MR masks CO even at 99 with en high.
    step(1'b0, 1'b1, 1'b0, 8'h99, 8'h02, 1'b0, 1'b0, 8'd23);
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h99, 1'b0, 1'b0, 8'd24);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd25);
    // Load with a low-digit carry boundary, then count across it.
    step(1'b0, 1'b1, 1'b0, 8'h29, 8'h00, 1'b0, 1'b0, 8'd26);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h29, 1'b0, 1'b0, 8'd27);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h30, 1'b0, 1'b0, 8'd28);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
